// File: rtl/nested_cfg_sequencer.sv
// Nested configuration chain sequencer: level k follows level k-1, optionally inverted.
// Optional build macro: NESTED_CFG_SEQ_CHECK_EN enables the final-level check (chk_err).
module nested_cfg_sequencer #(
    parameter int               W        = 2,
    parameter int               DEPTH    = 2,
    parameter logic [DEPTH-1:0] INV_MASK = '0,
    parameter logic [W-1:0]     DEFAULT  = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [W-1:0]       req_data,
    output logic [DEPTH*W-1:0] cfg_out,
    output logic [W-1:0]       cfg_final,
    output logic               busy,
    output logic               done,
    output logic               chk_err
);

    localparam int IW = $clog2(DEPTH + 1);

    function automatic logic [DEPTH*W-1:0] reset_chain();
        logic [DEPTH*W-1:0] c;
        logic [W-1:0]       v;
        v = DEFAULT;
        c = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k != 0 && INV_MASK[k]) v = ~v;
            c[k*W +: W] = v;
        end
        return c;
    endfunction

    localparam logic [DEPTH*W-1:0] RST_CFG = reset_chain();

    typedef enum logic [1:0] {
        IDLE,
        PROP,
        DONE
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      idx_q;
    logic [W-1:0]       hold_q;
    logic [DEPTH*W-1:0] cfg_q;
    logic [W-1:0]       next_lvl;

    // value for the level currently addressed by idx_q
    always_comb begin
        next_lvl = hold_q;
        for (int k = 1; k < DEPTH; k++) begin
            if (idx_q == IW'(k)) begin
                next_lvl = INV_MASK[k] ? ~cfg_q[(k-1)*W +: W]
                                       :  cfg_q[(k-1)*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            cfg_q   <= RST_CFG;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        hold_q  <= req_data;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= PROP;
                    end
                end
                PROP: begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (idx_q == IW'(k)) cfg_q[k*W +: W] <= next_lvl;
                    end
                    if (idx_q == IW'(DEPTH - 1)) begin
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE) & ~rst;
    assign cfg_out   = cfg_q;
    assign cfg_final = cfg_q[(DEPTH-1)*W +: W];

`ifdef NESTED_CFG_SEQ_CHECK_EN
    function automatic logic mask_par();
        logic p;
        p = 1'b0;
        for (int k = 1; k < DEPTH; k++) p = p ^ INV_MASK[k];
        return p;
    endfunction

    localparam logic MASK_PAR = mask_par();

    logic [W-1:0] exp_final;
    assign exp_final = hold_q ^ {W{MASK_PAR}};

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else if (state_q == DONE && cfg_final != exp_final) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_nested_cfg_sequencer.sv
// Bench for nested_cfg_sequencer: vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_nested_cfg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_v, b_v;
    logic [1:0] a_d, b_d;
    logic       a_rdy, a_bsy, a_dn, a_err;
    logic [3:0] a_cfg;
    logic [1:0] a_fin;
    logic       b_rdy, b_bsy, b_dn, b_err;
    logic [5:0] b_cfg;
    logic [1:0] b_fin;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nested_cfg_sequencer #(
        .W(2), .DEPTH(2), .INV_MASK(2'b10), .DEFAULT(2'b11)
    ) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_v), .req_ready(a_rdy),
        .req_data(a_d), .cfg_out(a_cfg), .cfg_final(a_fin),
        .busy(a_bsy), .done(a_dn), .chk_err(a_err)
    );

    nested_cfg_sequencer #(
        .W(2), .DEPTH(3), .INV_MASK(3'b110), .DEFAULT(2'b11)
    ) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_v), .req_ready(b_rdy),
        .req_data(b_d), .cfg_out(b_cfg), .cfg_final(b_fin),
        .busy(b_bsy), .done(b_dn), .chk_err(b_err)
    );

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    typedef struct {
        logic       v;
        logic [1:0] d;
        logic       rdy;
        logic       bsy;
        logic       dn;
        logic [3:0] cfg;
    } vec_t;

    vec_t tv[9];

    // Reference model: level k of the chain equals source ^ parity(mask[1..k]).
    localparam logic [1:0] M_MASK = 2'b10;
    localparam logic [1:0] M_DEF  = 2'b11;
    int         m_t;
    logic [1:0] m_hold;
    logic [1:0] m_lv[2];

    function automatic logic [1:0] chain(input logic [1:0] src, input int k);
        logic p;
        logic [1:0] mk;
        mk = M_MASK;
        p = 1'b0;
        for (int j = 1; j <= k; j++) p = p ^ mk[j];
        return src ^ {2{p}};
    endfunction

    task automatic m_reset();
        m_t = -1;
        m_hold = '0;
        for (int k = 0; k < 2; k++) m_lv[k] = chain(M_DEF, k);
    endtask

    task automatic m_step(input logic r, input logic v, input logic [1:0] d);
        if (r) begin
            m_reset();
        end else if (m_t < 0) begin
            if (v) begin
                m_hold = d;
                m_t = 0;
            end
        end else if (m_t < 2) begin
            m_lv[m_t] = chain(m_hold, m_t);
            m_t++;
        end else begin
            m_t = -1;
        end
    endtask

    initial begin
        rst = 1'b1;
        a_v = 1'b0; a_d = '0;
        b_v = 1'b0; b_d = '0;

        tv[0] = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 4'b0011};
        tv[1] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0001};
        tv[2] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 4'b1001};
        tv[3] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'b1001};
        tv[4] = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 4'b1001};
        tv[5] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 4'b1010};
        tv[6] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 4'b0110};
        tv[7] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0110};
        tv[8] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0110};

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rdy_in_rst", a_rdy, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_cfg", a_cfg, 4'b0011);
        chk("rst_final", a_fin, 2'b00);
        chk("rst_rdy", a_rdy, 1'b1);
        chk("rst_done", a_dn, 1'b0);
        chk("rst_busy", a_bsy, 1'b0);
        chk("rst_err", a_err, 1'b0);
        chk("b_rst_cfg", b_cfg, 6'b110011);

        // basic request and back-to-back hold
        for (int i = 0; i < 9; i++) begin
            a_v = tv[i].v;
            a_d = tv[i].d;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_rdy", i), a_rdy, tv[i].rdy);
            chk($sformatf("vec%0d_busy", i), a_bsy, tv[i].bsy);
            chk($sformatf("vec%0d_done", i), a_dn, tv[i].dn);
            chk($sformatf("vec%0d_cfg", i), a_cfg, tv[i].cfg);
            chk($sformatf("vec%0d_fin", i), a_fin, tv[i].cfg[3:2]);
        end

        // reset mid-PROP
        a_v = 1'b1; a_d = 2'b01;
        @(posedge clk);
        @(negedge clk);
        a_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_cfg_e1", a_cfg, 4'b0101);
        rst = 1'b1;
        #1;
        chk("mid_rdy_rst", a_rdy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_cfg_rst", a_cfg, 4'b0011);
        chk("mid_busy", a_bsy, 1'b0);
        chk("mid_done", a_dn, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("mid_no_done", a_dn, 1'b0);
            chk("mid_idle_busy", a_bsy, 1'b0);
        end

        // DEPTH=3 instance
        b_v = 1'b1; b_d = 2'b10;
        @(posedge clk);
        @(negedge clk);
        b_v = 1'b0;
        chk("b_busy_e0", b_bsy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("b_cfg_e1", b_cfg, 6'b110010);
        chk("b_done_e1", b_dn, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("b_cfg_e2", b_cfg, 6'b110110);
        chk("b_done_e2", b_dn, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("b_cfg_e3", b_cfg, 6'b100110);
        chk("b_fin_e3", b_fin, 2'b10);
        chk("b_done_e3", b_dn, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("b_done_e4", b_dn, 1'b0);
        chk("b_rdy_e4", b_rdy, 1'b1);
        chk("b_err", b_err, 1'b0);

        // final-level check
`ifdef NESTED_CFG_SEQ_CHECK_EN
        force dut_a.cfg_final = 2'b11;
        a_v = 1'b1; a_d = 2'b01;
        @(posedge clk);
        @(negedge clk);
        a_v = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("chk_err_set", a_err, 1'b1);
        release dut_a.cfg_final;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("chk_err_sticky", a_err, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("chk_err_clr", a_err, 1'b0);
`else
        chk("chk_err_off", a_err, 1'b0);
`endif

        // randomized traffic vs model
        for (int c = 0; c < 400; c++) begin
            logic       r, v;
            logic [1:0] d;
            r = (c == 0) || ($urandom_range(0, 40) == 0);
            v = 1'($urandom_range(0, 1));
            d = 2'($urandom_range(0, 3));
            rst = r; a_v = v; a_d = d;
            @(posedge clk);
            m_step(r, v, d);
            @(negedge clk);
            chk("rnd_cfg", a_cfg, {m_lv[1], m_lv[0]});
            chk("rnd_fin", a_fin, m_lv[1]);
            chk("rnd_done", a_dn, m_t == 2);
            chk("rnd_busy", a_bsy, m_t >= 0);
            chk("rnd_rdy", a_rdy, (m_t < 0) && !r);
            chk("rnd_err", a_err, 1'b0);
        end
        rst = 1'b0;
        a_v = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
